switch_box_config_loader: RTL



---
 rtl/switch_box_config_loader_if.sv | 11 +
 rtl/switch_box_config_loader.sv | 87 ++++++++
 2 files changed

// File: rtl/switch_box_config_loader_if.sv
// Byte-stream configuration handshake between the fabric config controller
// and a switch box configuration loader.
interface switch_box_config_loader_if;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;

  modport master (output cfg_start, output cfg_valid, output cfg_data, input  cfg_ready);
  modport slave  (input  cfg_start, input  cfg_valid, input  cfg_data, output cfg_ready);
endinterface

// File: rtl/switch_box_config_loader.sv
// Assembles a checksummed byte stream into a shadow register and commits the
// whole universal_switch_box configuration word in one cycle on a match.
module switch_box_config_loader #(
  parameter  int WS = 7,
  parameter  int WD = 6,
  localparam int CW = WS * 6 + WD / 2 * 6,
  localparam int NB = (CW + 7) / 8
) (
  input  logic                        clk,
  input  logic                        rst,
  switch_box_config_loader_if.slave   bus,
  output logic [CW-1:0]               c,
  output logic                        c_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int BCW = $clog2(NB + 1);
  localparam logic [BCW-1:0] LAST_IDX = BCW'(NB - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t            r_state;
  logic [8*NB-1:0]   r_shadow;
  logic [BCW-1:0]    r_byte_cnt;
  logic [7:0]        r_chk;
  logic              w_xfer;

  // A start pulse always wins over a byte offered in the same cycle.
  assign bus.cfg_ready = (r_state != S_IDLE) && !bus.cfg_start;
  assign w_xfer        = bus.cfg_valid && bus.cfg_ready;
  assign busy          = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shadow   <= '0;
      r_byte_cnt <= '0;
      r_chk      <= '0;
      c          <= '0;
      c_valid    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.cfg_start) begin
        r_state    <= S_LOAD;
        r_shadow   <= '0;
        r_byte_cnt <= '0;
        r_chk      <= '0;
        err        <= 1'b0;
      end else begin
        case (r_state)
          S_LOAD: begin
            if (w_xfer) begin
              for (int k = 0; k < NB; k++) begin
                if (r_byte_cnt == BCW'(k)) r_shadow[8*k +: 8] <= bus.cfg_data;
              end
              r_chk      <= r_chk ^ bus.cfg_data;
              r_byte_cnt <= r_byte_cnt + 1'b1;
              if (r_byte_cnt == LAST_IDX) r_state <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (w_xfer) begin
              if (bus.cfg_data == r_chk) begin
                c       <= r_shadow[CW-1:0];
                c_valid <= 1'b1;
              end else begin
                err <= 1'b1;
              end
              done    <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
